// File: rtl/kyber_coef_packer.sv
// Collects a polynomial's coefficient stream into PE_NUMBER-lane words, then emits them to the core.
// Optional COEF_REDUCE_EN: subtract q=3329 from any incoming coefficient >= q before storage.
module kyber_coef_packer #(
  parameter int unsigned PE_NUMBER = 16,
  parameter int unsigned NCOEF     = 256
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [1:0]                sel,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [11:0]               s_data,
  input  logic                      s_last,
  output logic [12*PE_NUMBER-1:0]   din,
  output logic                      load_a_f,
  output logic                      load_a_i,
  output logic                      load_b_f,
  output logic                      load_b_i,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  localparam int unsigned NWORDS = NCOEF / PE_NUMBER;
  localparam int unsigned CW     = $clog2(NCOEF);
  localparam int unsigned EW     = $clog2(NWORDS + 1);
  localparam int unsigned WW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int unsigned LW     = (PE_NUMBER > 1) ? $clog2(PE_NUMBER) : 1;

  typedef enum logic [1:0] {IDLE, FILL, EMIT} state_t;

  state_t                   state;
  logic [CW-1:0]            n;
  logic [EW-1:0]            e;
  logic [1:0]               sel_q;
  logic [12*PE_NUMBER-1:0]  buffer [NWORDS];
  logic [11:0]              coef;
  logic                     accept;
  logic [WW-1:0]            widx;
  logic [LW-1:0]            lidx;

`ifdef COEF_REDUCE_EN
  assign coef = (s_data >= 12'd3329) ? s_data - 12'd3329 : s_data;
`else
  assign coef = s_data;
`endif

  assign accept = s_valid && s_ready;
  assign widx   = WW'(32'(n) / PE_NUMBER);
  assign lidx   = LW'(32'(n) % PE_NUMBER);

  // Buffer is datapath only; its contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      buffer[widx][12*lidx +: 12] <= coef;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      n        <= '0;
      e        <= '0;
      sel_q    <= 2'b00;
      s_ready  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      din      <= '0;
      load_a_f <= 1'b0;
      load_a_i <= 1'b0;
      load_b_f <= 1'b0;
      load_b_i <= 1'b0;
    end else begin
      load_a_f <= 1'b0;
      load_a_i <= 1'b0;
      load_b_f <= 1'b0;
      load_b_i <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state   <= FILL;
            sel_q   <= sel;
            n       <= '0;
            err     <= 1'b0;
            s_ready <= 1'b1;
            busy    <= 1'b1;
          end
        end
        FILL: begin
          if (accept) begin
            n <= n + 1'b1;
            if (n == CW'(NCOEF - 1)) begin
              // Full polynomial received; a missing s_last is flagged but not fatal.
              state    <= EMIT;
              e        <= '0;
              s_ready  <= 1'b0;
              load_a_f <= (sel_q == 2'b00);
              load_a_i <= (sel_q == 2'b01);
              load_b_f <= (sel_q == 2'b10);
              load_b_i <= (sel_q == 2'b11);
              if (!s_last) begin
                err <= 1'b1;
              end
            end else if (s_last) begin
              state   <= IDLE;
              err     <= 1'b1;
              s_ready <= 1'b0;
              busy    <= 1'b0;
            end
          end
        end
        EMIT: begin
          if (e == EW'(NWORDS)) begin
            state <= IDLE;
            din   <= '0;
            done  <= 1'b0;
            busy  <= 1'b0;
          end else begin
            din  <= buffer[e[WW-1:0]];
            done <= (e == EW'(NWORDS - 1));
            e    <= e + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kyber_coef_packer.sv
// Scoreboard bench for kyber_coef_packer: expected strobe/word beats are queued as coefficients
// are accepted and checked against the DUT output stream on the falling edge.
module tb_kyber_coef_packer;

  localparam int unsigned PE = 16;
  localparam int unsigned NC = 256;
  localparam int unsigned NW = NC / PE;
  localparam int unsigned DW = 12 * PE;

  logic          clk = 1'b0;
  logic          reset, start, s_valid, s_ready, s_last;
  logic [1:0]    sel;
  logic [11:0]   s_data;
  logic [DW-1:0] din;
  logic          load_a_f, load_a_i, load_b_f, load_b_i;
  logic          busy, done, err;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [3:0]    strb;
    logic          done;
    logic [DW-1:0] word;
  } beat_t;

  beat_t       exp_q[$];
  logic [11:0] coef [NC];
  int          wc = 0;

  always #5 clk = ~clk;

  kyber_coef_packer #(.PE_NUMBER(PE), .NCOEF(NC)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .sel      (sel),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_last   (s_last),
    .din      (din),
    .load_a_f (load_a_f),
    .load_a_i (load_a_i),
    .load_b_f (load_b_f),
    .load_b_i (load_b_i),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [11:0] model(input logic [11:0] v);
`ifdef COEF_REDUCE_EN
    return (v >= 12'd3329) ? v - 12'd3329 : v;
`else
    return v;
`endif
  endfunction

  // Output monitor: a strobe opens a window of NW word beats.
  always @(negedge clk) begin
    logic [3:0] strb;
    beat_t      b;
    strb = {load_b_i, load_b_f, load_a_i, load_a_f};
    if (reset) begin
      wc = 0;
    end else if (strb != 4'b0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", DW'(strb), DW'(0));
      end else begin
        b = exp_q.pop_front();
        check("strobe", DW'(strb), DW'(b.strb));
      end
      wc = NW;
    end else if (wc > 0) begin
      if (exp_q.size() == 0) begin
        check("missing_beat", DW'(din), DW'(0));
        wc = 0;
      end else begin
        b = exp_q.pop_front();
        check("word", din, b.word);
        check("done", DW'(done), DW'(b.done));
        wc--;
      end
    end else if (din != '0 || done) begin
      check("idle_out", DW'({din != '0, done}), DW'(0));
    end
  end

  task automatic run_poly(input logic [1:0] sl, input bit rnd, input int last_idx,
                          input int abort_at, input int mid_start_at);
    logic [DW-1:0] w [NW];
    beat_t         b;
    int            n = 0;
    int            cyc = 0;
    bit            first = 1'b1;
    bit            fin = 1'b0;
    @(negedge clk);
    start = 1'b1;
    sel   = sl;
    while (!fin && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (first) begin
        check("ready_latency", DW'(s_ready), DW'(1));
        check("err_cleared", DW'(err), DW'(0));
        first = 1'b0;
      end
      if (n == abort_at) begin
        reset   = 1'b1;
        s_valid = 1'b0;
        #1;
        check("reset_ctrl", DW'({s_ready, busy, done, err, load_a_f, load_a_i, load_b_f, load_b_i}),
              DW'(0));
        check("reset_din", din, DW'(0));
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      if (n == mid_start_at) begin
        start = 1'b1;
        sel   = ~sl;
      end
      s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data  = coef[n];
      s_last  = (n == last_idx);
      if (s_valid && s_ready) begin
        w[n/PE][12*(n%PE) +: 12] = model(coef[n]);
        if (n == NC - 1) begin
          b.strb = 4'b0001 << sl;
          b.done = 1'b0;
          b.word = '0;
          exp_q.push_back(b);
          for (int i = 0; i < NW; i++) begin
            b.strb = 4'b0;
            b.done = (i == NW - 1);
            b.word = w[i];
            exp_q.push_back(b);
          end
          fin = 1'b1;
        end else if (n == last_idx) begin
          fin = 1'b1;
        end
        n++;
      end
    end
    check("fill_complete", DW'(fin), DW'(1));
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    start   = 1'b0;
    if (last_idx >= 0 && last_idx < NC - 1) begin
      check("early_last_err", DW'(err), DW'(1));
      check("early_last_idle", DW'({busy, s_ready}), DW'(0));
    end else begin
      check("busy_emit", DW'(busy), DW'(1));
      cyc = 0;
      while (!done && cyc < 40) begin
        @(negedge clk);
        cyc++;
      end
      check("done_seen", DW'(done), DW'(1));
      check("err_final", DW'(err), DW'(last_idx == NC - 1 ? 0 : 1));
    end
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    sel     = 2'b00;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    #12;
    check("rst_ctrl", DW'({s_ready, busy, done, err, load_a_f, load_a_i, load_b_f, load_b_i}),
          DW'(0));
    check("rst_din", din, DW'(0));
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NC; i++) coef[i] = 12'(i % 3329);
    run_poly(2'b00, 1'b0, NC - 1, -1, -1);
    // Back-to-back, random valid gaps, same data to b_i.
    run_poly(2'b11, 1'b1, NC - 1, -1, -1);
    for (int i = 0; i < NC; i++) coef[i] = 12'($urandom_range(0, 4095));
    // Back-to-back again, with a start pulse mid-FILL that must be ignored.
    run_poly(2'b01, 1'b1, NC - 1, -1, 50);

    run_poly(2'b10, 1'b0, 100, -1, -1);
    repeat (25) @(negedge clk);
    // No s_last at all: err but data still emitted.
    run_poly(2'b10, 1'b0, -1, -1, -1);

    run_poly(2'b00, 1'b1, NC - 1, 200, -1);
    repeat (25) @(negedge clk);
    check("post_reset_err", DW'(err), DW'(0));
    for (int i = 0; i < NC; i++) coef[i] = 12'($urandom_range(0, 4095));
    run_poly(2'b10, 1'b0, NC - 1, -1, -1);

    for (int i = 0; i < NC; i++) begin
      case (i % 4)
        0:       coef[i] = 12'd4095;
        1:       coef[i] = 12'd3329;
        2:       coef[i] = 12'd3328;
        default: coef[i] = 12'(i);
      endcase
    end
    run_poly(2'b01, 1'b0, NC - 1, -1, -1);

    repeat (5) @(negedge clk);
    check("queue_empty", DW'(exp_q.size()), DW'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
